// File: rtl/result_stats.sv
// Captures a burst of signed results and emits a 4-beat summary afterwards:
// min, max, saturated sum and sample count, plus an overflow flag for long bursts.
module result_stats #(
  parameter int DATA_W  = 7,
  parameter int SUM_W   = 10,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  output logic              busy,
  output logic              out_valid,
  output logic [1:0]        out_sel,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_ovf
);

  typedef enum logic [2:0] {IDLE, ACC, S_MIN, S_MAX, S_SUM, S_CNT} state_t;

  localparam logic signed [SUM_W:0] SUM_MAX = {2'b00, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] SUM_MIN = {2'b11, {(SUM_W-1){1'b0}}};

  state_t state_q, state_d;
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [SUM_W-1:0]  out_data_q, out_data_d;

  logic [SUM_W-1:0]         sample_ext;
  logic signed [SUM_W:0]    sum_wide;
  logic [SUM_W-1:0]         sum_sat;

  // One extra bit of headroom lets the clamp see the true overflowed sum.
  always_comb begin
    sample_ext = {{(SUM_W-DATA_W){in_result[DATA_W-1]}}, in_result};
    sum_wide   = {sum_q[SUM_W-1], sum_q} + {sample_ext[SUM_W-1], sample_ext};
    if (sum_wide > SUM_MAX) begin
      sum_sat = SUM_MAX[SUM_W-1:0];
    end else if (sum_wide < SUM_MIN) begin
      sum_sat = SUM_MIN[SUM_W-1:0];
    end else begin
      sum_sat = sum_wide[SUM_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ACC;
          min_d   = in_result;
          max_d   = in_result;
          sum_d   = sample_ext;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (cnt_q < CNT_W'(MAX_LEN)) begin
            if ($signed(in_result) < $signed(min_q)) min_d = in_result;
            if ($signed(in_result) > $signed(max_q)) max_d = in_result;
            sum_d = sum_sat;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d     = S_MIN;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_sel_d   = 2'd0;
          out_data_d  = {{(SUM_W-DATA_W){min_q[DATA_W-1]}}, min_q};
        end
      end
      S_MIN: begin
        state_d    = S_MAX;
        out_sel_d  = 2'd1;
        out_data_d = {{(SUM_W-DATA_W){max_q[DATA_W-1]}}, max_q};
      end
      S_MAX: begin
        state_d    = S_SUM;
        out_sel_d  = 2'd2;
        out_data_d = sum_q;
      end
      S_SUM: begin
        state_d    = S_CNT;
        out_sel_d  = 2'd3;
        out_data_d = {{(SUM_W-CNT_W){1'b0}}, cnt_q};
      end
      S_CNT: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_sel_d   = 2'd0;
        out_data_d  = '0;
        ovf_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      min_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 2'd0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_result_stats.sv
// Directed self-checking bench for result_stats: bursts, saturation, overflow,
// samples offered while busy, and reset aborts in ACC and mid-summary.
module tb_result_stats;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] in_result;
  logic       busy;
  logic       out_valid;
  logic [1:0] out_sel;
  logic [9:0] out_data;
  logic       out_ovf;

  int errors = 0;
  int checks = 0;

  result_stats #(.DATA_W(7), .SUM_W(10), .MAX_LEN(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_result (in_result),
    .busy      (busy),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int d);
    @(negedge clk);
    in_valid  = v;
    in_result = 7'(d);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"}, {31'b0, out_valid}, 0);
    checkOutput({tag, " busy"},  {31'b0, busy},      0);
    checkOutput({tag, " sel"},   {30'b0, out_sel},   0);
    checkOutput({tag, " data"},  $signed(out_data),  0);
    checkOutput({tag, " ovf"},   {31'b0, out_ovf},   0);
  endtask

  // Call right after the negedge that drove in_valid low after the last sample.
  task automatic checkSummary(input string tag, input int mn, input int mx, input int sm,
                              input int cn, input logic ovf, input logic hold);
    int exp_d[4];
    exp_d = '{mn, mx, sm, cn};
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checkOutput($sformatf("%s beat%0d valid", tag, b), {31'b0, out_valid}, 1);
      checkOutput($sformatf("%s beat%0d busy", tag, b),  {31'b0, busy},      1);
      checkOutput($sformatf("%s beat%0d sel", tag, b),   {30'b0, out_sel},   b);
      checkOutput($sformatf("%s beat%0d data", tag, b),  $signed(out_data),  exp_d[b]);
      checkOutput($sformatf("%s beat%0d ovf", tag, b),   {31'b0, out_ovf},   {31'b0, ovf});
      in_valid  = hold;
      in_result = 7'd50;
    end
    @(negedge clk);
    checkIdle({tag, " after"});
    in_valid  = 1'b0;
    in_result = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic mixed-sign burst
    applyStimulus(1, 3);
    applyStimulus(1, -5);
    applyStimulus(1, 7);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkSummary("mixed", -5, 7, 5, 4, 1'b0, 1'b0);

    // Single most-negative sample
    applyStimulus(1, -64);
    applyStimulus(0, 0);
    checkSummary("single", -64, -64, -64, 1, 1'b0, 1'b0);

    // Positive saturation with exactly MAX_LEN samples
    for (int i = 0; i < 16; i++) applyStimulus(1, 63);
    applyStimulus(0, 0);
    checkSummary("satpos", 63, 63, 511, 16, 1'b0, 1'b0);

    // Negative saturation
    for (int i = 0; i < 16; i++) applyStimulus(1, -64);
    applyStimulus(0, 0);
    checkSummary("satneg", -64, -64, -512, 16, 1'b0, 1'b0);

    // Clamped sum keeps accumulating from the clamp value: 511 - 64 = 447
    for (int i = 0; i < 9; i++) applyStimulus(1, 63);
    applyStimulus(1, -64);
    applyStimulus(0, 0);
    checkSummary("sticky", -64, 63, 447, 10, 1'b0, 1'b0);

    // Over-long burst: last 4 samples dropped, ovf on every beat
    for (int i = 0; i < 20; i++) applyStimulus(1, 1);
    applyStimulus(0, 0);
    checkSummary("ovf", 1, 1, 16, 16, 1'b1, 1'b0);

    // Samples offered during the summary are ignored
    applyStimulus(1, 2);
    applyStimulus(1, 4);
    applyStimulus(0, 0);
    checkSummary("busy", 2, 4, 6, 2, 1'b0, 1'b1);
    @(negedge clk);
    checkIdle("busy settle");
    applyStimulus(1, -3);
    applyStimulus(0, 0);
    checkSummary("postbusy", -3, -3, -3, 1, 1'b0, 1'b0);

    // Reset while accumulating
    applyStimulus(1, 10);
    applyStimulus(1, 20);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkIdle("rst acc");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkIdle($sformatf("rst acc hold%0d", i));
    end

    // Reset in S_MAX, after the min and max beats
    applyStimulus(1, 9);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("rst smax min beat", $signed(out_data), 9);
    @(negedge clk);
    checkOutput("rst smax max sel", {30'b0, out_sel}, 1);
    rst_n = 1'b0;
    #1;
    checkIdle("rst smax");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkIdle($sformatf("rst smax hold%0d", i));
    end

    // Stats recover after reset
    applyStimulus(1, -1);
    applyStimulus(1, 5);
    applyStimulus(0, 0);
    checkSummary("recover", -1, 5, 4, 2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
